// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the 32-bit datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback
// states. The single shared memory port is handled with a mem_ready handshake
// and a bounded wait. Illegal opcodes and memory timeouts trap until reset.
// Optional feature: define MULTICYCLE_CTRL_PERF_CNT_EN to add the
// retired-instruction counter output `retired` (width CNT_W).
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_ncond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       halted
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  // Opcodes (instr[31:24]).
  localparam logic [7:0] OpRType = 8'h00;
  localparam logic [7:0] OpJ     = 8'h02;
  localparam logic [7:0] OpBeq   = 8'h04;
  localparam logic [7:0] OpBne   = 8'h05;
  localparam logic [7:0] OpAddi  = 8'h08;
  localparam logic [7:0] OpLw    = 8'h23;
  localparam logic [7:0] OpSw    = 8'h2B;

  // Wait-counter value at which a further not-ready cycle times out.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StRWb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12,
    StTrap    = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_wait_st;
  logic       timed_out;

  // The zero flag gates pc_write_cond/pc_write_ncond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timed_out   = !mem_ready && (wait_cnt_q == WaitLast);

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        // A completing access on the timeout cycle takes priority over the trap.
        if (mem_ready)      state_d = StDecode;
        else if (timed_out) state_d = StTrap;
      end
      StDecode: begin
        case (opcode)
          OpRType:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StAddiEx;
          default:     state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        // Only LW/SW reach here, and the instruction register holds the opcode.
        state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        if (mem_ready)      state_d = StMemWb;
        else if (timed_out) state_d = StTrap;
      end
      StMemWb:  state_d = StFetch;
      StMemWr: begin
        if (mem_ready)      state_d = StFetch;
        else if (timed_out) state_d = StTrap;
      end
      StExec:   state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  // Wait counter: cleared on any state change, counts stalled memory cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (mem_wait_st && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Control outputs decoded from the current state.
  always_comb begin
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    pc_write_ncond = 1'b0;
    pc_source      = 2'd0;
    iord           = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    reg_dest       = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'd0;
    alu_op         = 2'd0;
    halted         = 1'b0;
    case (state_q)
      StFetch: begin
        // PC + 4 computed every cycle; IR and PC only load once memory responds.
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        // Precompute the branch target into ALU-out.
        alu_src_b = 2'd3;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      StBranch: begin
        alu_src_a      = 1'b1;
        alu_op         = 2'd1;
        pc_source      = 2'd1;
        pc_write_cond  = (opcode == OpBeq);
        pc_write_ncond = (opcode == OpBne);
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
      StTrap: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic             retire_evt;

  // Re-entering FETCH from inside an instruction marks one retired instruction.
  assign retire_evt = (state_d == StFetch) && (state_q != StFetch) && (state_q != StIdle) &&
                      (state_q != StTrap);

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire_evt) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;
`endif

endmodule
